// File: rtl/ca2_pkg.sv
// Shared constants for the truth-table checker: FSM state encoding and
// reference truth tables for the common two-input cells.
package ca2_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_APPLY  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Bit i is the expected cell output for input vector i (stim[0] = a).
   localparam logic [3:0] TT_AND2 = 4'b1000;
   localparam logic [3:0] TT_OR2  = 4'b1110;
   localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter that times the settle window of each applied vector.
// Load takes effect on the next edge; zero is high when the count has expired.
module settle_counter #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic zero
);

   localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   logic [W-1:0] cnt;

   // Loading SETTLE-1 gives exactly SETTLE cycles before zero is seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(SETTLE - 1);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a combinational cell in ascending order, samples the
// cell after a settle window and scores it against the EXPECTED truth table.
module truth_table_checker
   import ca2_pkg::*;
#(
   parameter int                  N_IN     = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECTED = TT_AND2,
   parameter int                  SETTLE   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] stim,
   input  logic            res_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail
);

   localparam logic [N_IN-1:0] LAST_IDX = '1;

   logic [1:0]      state;
   logic [N_IN-1:0] idx;
   logic            mismatch;
   logic            settle_load;
   logic            settle_en;
   logic            settle_zero;

   assign mismatch    = (res_in != EXPECTED[idx]);
   assign settle_load = ((state == ST_IDLE) && start) ||
                        ((state == ST_SAMPLE) && (idx != LAST_IDX));
   assign settle_en   = (state == ST_APPLY);

   settle_counter #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk  (clk),
      .rst  (rst),
      .load (settle_load),
      .en   (settle_en),
      .zero (settle_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         stim       <= '0;
         err_count  <= '0;
         first_fail <= '0;
         pass       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx        <= '0;
                  stim       <= '0;
                  err_count  <= '0;
                  first_fail <= '0;
                  pass       <= 1'b0;
                  state      <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (settle_zero) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  if (err_count == '0) begin
                     first_fail <= idx;
                  end
               end
               // Verdict lands on the same edge as done, so it folds in this last sample.
               if (idx == LAST_IDX) begin
                  pass  <= (err_count == '0) && !mismatch;
                  state <= ST_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  stim  <= idx + 1'b1;
                  state <= ST_APPLY;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checkers (SETTLE=1 and SETTLE=3) each scoring a selectable
// two-input cell (AND, OR, or output stuck at 1) against the AND truth table.
module tb_truth_table_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, start_b;
   int         mode;

   logic [1:0] stim_a, stim_b;
   logic       res_a, res_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [2:0] err_a, err_b;
   logic [1:0] ff_a, ff_b;

   int checks = 0;
   int errors = 0;

   function automatic logic cut(input int m, input logic [1:0] s);
      case (m)
         0:       return s[0] & s[1];
         1:       return s[0] | s[1];
         default: return 1'b1;
      endcase
   endfunction

   assign res_a = cut(mode, stim_a);
   assign res_b = cut(mode, stim_b);

   truth_table_checker #(
      .N_IN     (2),
      .EXPECTED (4'b1000),
      .SETTLE   (1)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a),
      .stim       (stim_a),
      .res_in     (res_a),
      .busy       (busy_a),
      .done       (done_a),
      .pass       (pass_a),
      .err_count  (err_a),
      .first_fail (ff_a)
   );

   truth_table_checker #(
      .N_IN     (2),
      .EXPECTED (4'b1000),
      .SETTLE   (3)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .stim       (stim_b),
      .res_in     (res_b),
      .busy       (busy_b),
      .done       (done_b),
      .pass       (pass_b),
      .err_count  (err_b),
      .first_fail (ff_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start_a = v;
      else          start_b = v;
   endtask

   // Pulses start before edge 0, then checks every edge through L+1.
   // rep >= 0 re-asserts start for the edge numbered rep, which must be ignored.
   task automatic run(input string name, input int sel, input int settle,
                      input int exp_err, input int exp_ff, input int exp_pass, input int rep);
      int L;
      int exp_stim;
      L = 4 * (settle + 1);
      set_start(sel, 1'b1);
      for (int k = 0; k <= L + 1; k++) begin
         @(posedge clk);
         #1;
         set_start(sel, (k + 1 == rep) ? 1'b1 : 1'b0);
         exp_stim = (k < L) ? k / (settle + 1) : 3;
         if (sel == 0) begin
            check($sformatf("%s stim@%0d", name, k), {30'd0, stim_a}, exp_stim);
            check($sformatf("%s done@%0d", name, k), {31'd0, done_a}, (k == L) ? 1 : 0);
            check($sformatf("%s busy@%0d", name, k), {31'd0, busy_a}, (k <= L) ? 1 : 0);
            if (k == L) begin
               check($sformatf("%s pass", name), {31'd0, pass_a}, exp_pass);
               check($sformatf("%s err_count", name), {29'd0, err_a}, exp_err);
               if (exp_err != 0)
                  check($sformatf("%s first_fail", name), {30'd0, ff_a}, exp_ff);
            end
         end else begin
            check($sformatf("%s stim@%0d", name, k), {30'd0, stim_b}, exp_stim);
            check($sformatf("%s done@%0d", name, k), {31'd0, done_b}, (k == L) ? 1 : 0);
            check($sformatf("%s busy@%0d", name, k), {31'd0, busy_b}, (k <= L) ? 1 : 0);
            if (k == L) begin
               check($sformatf("%s pass", name), {31'd0, pass_b}, exp_pass);
               check($sformatf("%s err_count", name), {29'd0, err_b}, exp_err);
               if (exp_err != 0)
                  check($sformatf("%s first_fail", name), {30'd0, ff_b}, exp_ff);
            end
         end
      end
   endtask

   task automatic check_reset_a(input string name);
      check({name, " stim"},       {30'd0, stim_a}, 0);
      check({name, " busy"},       {31'd0, busy_a}, 0);
      check({name, " done"},       {31'd0, done_a}, 0);
      check({name, " pass"},       {31'd0, pass_a}, 0);
      check({name, " err_count"},  {29'd0, err_a},  0);
      check({name, " first_fail"}, {30'd0, ff_a},   0);
   endtask

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      mode    = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_a("reset");
      check("reset b busy", {31'd0, busy_b}, 0);
      check("reset b stim", {30'd0, stim_b}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      mode = 0;
      run("and", 0, 1, 0, 0, 1, -1);
      mode = 1;
      run("or", 0, 1, 2, 1, 0, -1);
      mode = 2;
      run("tied1", 0, 1, 3, 0, 0, -1);
      mode = 0;
      run("settle3", 1, 3, 0, 0, 1, -1);
      run("repulse", 0, 1, 0, 0, 1, 3);

      // Abort a run with reset while vector 10 is in flight.
      mode = 1;
      set_start(0, 1'b1);
      for (int k = 0; k <= 4; k++) begin
         @(posedge clk);
         #1;
         set_start(0, 1'b0);
         check($sformatf("abort stim@%0d", k), {30'd0, stim_a}, k / 2);
         check($sformatf("abort busy@%0d", k), {31'd0, busy_a}, 1);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_a("abort@5");
      @(posedge clk);
      #1;
      check("abort done@6", {31'd0, done_a}, 0);
      check("abort busy@6", {31'd0, busy_a}, 0);
      mode = 0;
      run("restart", 0, 1, 0, 0, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
